// File: rtl/coffee_order_input.sv
// coffee_order_input: synchronizes and debounces the start button and coffee selection, then
// holds start_req until the slow downstream FSM acknowledges with busy or the hold time expires.
// Latency: stable raw press to start_req is DEBOUNCE_CYCLES+3 cycles; no backpressure, presses outside IDLE are dropped.
module coffee_order_input #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int HOLD_CYCLES     = 100_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_btn_raw,
   input  logic [1:0] sel_raw,
   input  logic       busy,
   output logic       start_req,
   output logic [1:0] coffee_sel,
   output logic       sel_err,
   output logic       timeout
);

   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_BUSY = 2'd2
   } state_t;

   // synchronizer stages
   logic            btn_s1_q, btn_s1_d;
   logic            btn_s2_q, btn_s2_d;
   logic [1:0]      sel_s1_q, sel_s1_d;
   logic [1:0]      sel_s2_q, sel_s2_d;

   // debouncer state
   logic            btn_deb_q, btn_deb_d;
   logic            btn_deb_prev_q, btn_deb_prev_d;
   logic [DB_W-1:0] btn_cnt_q, btn_cnt_d;
   logic [1:0]      sel_deb_q, sel_deb_d;
   logic [DB_W-1:0] sel_cnt_q, sel_cnt_d;

   // request FSM and registered outputs
   state_t            state_q, state_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              start_req_q, start_req_d;
   logic [1:0]        coffee_sel_q, coffee_sel_d;
   logic              sel_err_q, sel_err_d;
   logic              timeout_q, timeout_d;

   logic              press;

   // Two-flop synchronizers for the asynchronous button and switches.
   always_comb begin
      btn_s1_d = start_btn_raw;
      btn_s2_d = btn_s1_q;
      sel_s1_d = sel_raw;
      sel_s2_d = sel_s1_q;
   end

   // Button debouncer: the first-stage flop already holds next cycle's synchronized value,
   // so s1 == s2 means the synchronized value is not about to change.
   always_comb begin
      btn_deb_d      = btn_deb_q;
      btn_cnt_d      = '0;
      btn_deb_prev_d = btn_deb_q;
      if (btn_cnt_q == DB_LAST) begin
         btn_deb_d = btn_s2_q;
      end else if ((btn_s2_q != btn_deb_q) && (btn_s1_q == btn_s2_q)) begin
         btn_cnt_d = btn_cnt_q + DB_W'(1);
      end
   end

   // Selection debouncer: the 2-bit vector is treated as one value.
   always_comb begin
      sel_deb_d = sel_deb_q;
      sel_cnt_d = '0;
      if (sel_cnt_q == DB_LAST) begin
         sel_deb_d = sel_s2_q;
      end else if ((sel_s2_q != sel_deb_q) && (sel_s1_q == sel_s2_q)) begin
         sel_cnt_d = sel_cnt_q + DB_W'(1);
      end
   end

   // Single-cycle press event on the debounced rising edge; releases are ignored.
   always_comb begin
      press = btn_deb_q & ~btn_deb_prev_q;
   end

   // Request FSM next state and registered-output next values.
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      sel_err_d  = 1'b0;
      timeout_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // a press while downstream is still busy is dropped silently
            if (press && !busy) begin
               if (sel_deb_q == 2'b11) begin
                  sel_err_d = 1'b1;
               end else begin
                  state_d    = ST_REQ;
                  hold_cnt_d = '0;
               end
            end
         end
         ST_REQ: begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            // acknowledge wins over a timeout landing on the same cycle
            if (busy) begin
               state_d = ST_BUSY;
            end else if (hold_cnt_q == HOLD_LAST) begin
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (!busy) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      start_req_d = (state_d == ST_REQ);
      // coffee_sel tracks the debounced switches in IDLE and freezes for the whole order;
      // the value captured on entry to REQ is the selection the press was accepted with.
      if ((state_q != ST_IDLE) && (state_d != ST_IDLE)) begin
         coffee_sel_d = coffee_sel_q;
      end else begin
         coffee_sel_d = sel_deb_q;
      end
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         btn_s1_q       <= 1'b0;
         btn_s2_q       <= 1'b0;
         sel_s1_q       <= 2'b00;
         sel_s2_q       <= 2'b00;
         btn_deb_q      <= 1'b0;
         btn_deb_prev_q <= 1'b0;
         btn_cnt_q      <= '0;
         sel_deb_q      <= 2'b00;
         sel_cnt_q      <= '0;
         state_q        <= ST_IDLE;
         hold_cnt_q     <= '0;
         start_req_q    <= 1'b0;
         coffee_sel_q   <= 2'b00;
         sel_err_q      <= 1'b0;
         timeout_q      <= 1'b0;
      end else begin
         btn_s1_q       <= btn_s1_d;
         btn_s2_q       <= btn_s2_d;
         sel_s1_q       <= sel_s1_d;
         sel_s2_q       <= sel_s2_d;
         btn_deb_q      <= btn_deb_d;
         btn_deb_prev_q <= btn_deb_prev_d;
         btn_cnt_q      <= btn_cnt_d;
         sel_deb_q      <= sel_deb_d;
         sel_cnt_q      <= sel_cnt_d;
         state_q        <= state_d;
         hold_cnt_q     <= hold_cnt_d;
         start_req_q    <= start_req_d;
         coffee_sel_q   <= coffee_sel_d;
         sel_err_q      <= sel_err_d;
         timeout_q      <= timeout_d;
      end
   end

   assign start_req  = start_req_q;
   assign coffee_sel = coffee_sel_q;
   assign sel_err    = sel_err_q;
   assign timeout    = timeout_q;

endmodule
